// File: rtl/instr_readback_tx.sv
// Reads instruction words 0..num_words-1 and transmits each as ASCII binary digits
// (MSB first) followed by CR LF, through a built-in 8N1 serializer paced by a 16x baud tick.
`timescale 1ns/1ps
module instr_readback_tx #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 13,
  parameter int OS_TICKS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam int TW = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;
  localparam logic [CW-1:0]     LAST_DIGIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0]     CR_IDX     = CW'(DATA_W);
  localparam logic [CW-1:0]     LF_IDX     = CW'(DATA_W + 1);
  localparam logic [TW-1:0]     TICK_MAX   = TW'(OS_TICKS - 1);
  localparam logic [3:0]        STOP_BIT   = 4'd9;
  localparam logic [ADDR_W-1:0] ONE_WORD   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(0);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FRAME, DONE} state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   words_left_r, words_left_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic [CW-1:0]       char_idx_r, char_idx_s;
  logic [TW-1:0]       tick_r, tick_s;
  logic [3:0]          bit_idx_r, bit_idx_s;
  logic [9:0]          frame_r, frame_s;
  logic                tx_r, tx_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  // Character for a given position: a digit from the current MSB, then CR, then LF.
  function automatic logic [7:0] char_byte(input logic [CW-1:0] idx, input logic msb);
    if (idx == CR_IDX) begin
      return 8'h0D;
    end else if (idx == LF_IDX) begin
      return 8'h0A;
    end else begin
      return {7'b0011000, msb};
    end
  endfunction

  assign mem_addr = mem_addr_r;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      words_left_r <= ZERO_ADDR;
      mem_addr_r   <= ZERO_ADDR;
      shift_r      <= {DATA_W{1'b0}};
      char_idx_r   <= {CW{1'b0}};
      tick_r       <= {TW{1'b0}};
      bit_idx_r    <= 4'd0;
      frame_r      <= {10{1'b1}};
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      words_left_r <= words_left_s;
      mem_addr_r   <= mem_addr_s;
      shift_r      <= shift_s;
      char_idx_r   <= char_idx_s;
      tick_r       <= tick_s;
      bit_idx_r    <= bit_idx_s;
      frame_r      <= frame_s;
      tx_r         <= tx_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  // Next-state, serializer and output logic.
  always_comb begin
    state_s      = state_r;
    words_left_s = words_left_r;
    mem_addr_s   = mem_addr_r;
    shift_s      = shift_r;
    char_idx_s   = char_idx_r;
    tick_s       = tick_r;
    bit_idx_s    = bit_idx_r;
    frame_s      = frame_r;
    tx_s         = 1'b1;
    busy_s       = busy_r;
    done_s       = 1'b0;

    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          mem_addr_s = ZERO_ADDR;
          if (num_words == ZERO_ADDR) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            words_left_s = num_words;
            busy_s       = 1'b1;
            state_s      = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = LOAD;
      end
      LOAD: begin
        shift_s    = mem_data;
        char_idx_s = {CW{1'b0}};
        state_s    = SEND;
      end
      SEND: begin
        // Frame is shifted out LSB first: start bit, data, stop bit.
        frame_s   = {1'b1, char_byte(char_idx_r, shift_r[DATA_W-1]), 1'b0};
        tick_s    = {TW{1'b0}};
        bit_idx_s = 4'd0;
        if (char_idx_r <= LAST_DIGIT) begin
          shift_s = {shift_r[DATA_W-2:0], 1'b0};
        end else begin
          shift_s = shift_r;
        end
        state_s = FRAME;
      end
      FRAME: begin
        tx_s = frame_r[0];
        if (baud_tick) begin
          if (tick_r == TICK_MAX) begin
            tick_s = {TW{1'b0}};
            if (bit_idx_r == STOP_BIT) begin
              if (char_idx_r != LF_IDX) begin
                char_idx_s = char_idx_r + 1'b1;
                state_s    = SEND;
              end else if (words_left_r != ONE_WORD) begin
                words_left_s = words_left_r - 1'b1;
                mem_addr_s   = mem_addr_r + 1'b1;
                state_s      = FETCH;
              end else begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = DONE;
              end
            end else begin
              bit_idx_s = bit_idx_r + 1'b1;
              frame_s   = {1'b1, frame_r[9:1]};
            end
          end else begin
            tick_s = tick_r + 1'b1;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

endmodule
